polar_coord_fetch: RTL and testbench
====================================

# polar_coord_fetch

Sequencer directly upstream and downstream of the precalculation ROM. On each angular-step strobe it sweeps every LED index, drives the ROM address, captures the quadrant-local (x, y) the ROM returns, and applies quadrant rotation symmetry. It streams signed, centre-relative image coordinates to the framebuffer reader over a valid/ready handshake, with credit-based flow control so that no ROM read is ever lost.

## Interface
- NLEDS, 256, LEDs per arm (1..256); LED index runs 0..NLEDS-1
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle strobe: new angular position
- angle  in  9  full-turn angle, sampled with start; [8:7] quadrant, [6:0] angle within quadrant
- rom_addr  out  15  ROM address {angle[6:0], led[7:0]}
- rom_data  in  20  ROM read data; x = [7:0], y = [15:8], [19:16] ignored
- out_valid  out  1  coordinate available
- out_ready  in  1  consumer accepts
- out_x, out_y  out  9  signed centre-relative coordinates
- out_led  out  8  LED index of this coordinate
- out_last  out  1  marks LED NLEDS-1
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when the sweep completes

## Operation
- FSM: IDLE, ISSUE, DRAIN.
  - IDLE + start: latch angle, led_cnt=0, go to ISSUE.
  - start while not IDLE is ignored.
- ISSUE: one ROM read is issued per cycle when occ + inflight < 4.
  - occ is the output FIFO occupancy (0..4).
  - inflight counts reads in the address-register and ROM stages (0..2).
  - Each issue registers rom_addr and increments led_cnt.
  - After issuing LED NLEDS-1, go to DRAIN.
- DRAIN: wait until inflight=0 and occ=0 after the last handshake. Then pulse done and return to IDLE.
- busy=1 in ISSUE and DRAIN.
- A 2-stage tag pipeline (valid, led, quadrant) is aligned with the ROM latency. At the ROM-return stage it writes {rotated x, y, led, last} into the FIFO.
- Rotation, with x, y zero-extended to 9 bits signed:
  - q0 → (x, y)
  - q1 → (−y, x)
  - q2 → (−x, −y)
  - q3 → (y, −x)
  - Range is −255..255; no overflow is possible.
- Output is a handshake on out_valid && out_ready. Outputs are stable while out_valid=1 and out_ready=0.
- rom_addr holds its last value when no read is issued.

## Timing
- Reset values: rom_addr=0, out_valid=0, out_x/out_y/out_led/out_last=0, busy=0, done=0. FSM goes to IDLE, FIFO is empty, inflight=0, and in-flight tags are dropped.
- Start sampled at edge E0:
  - rom_addr(led 0) is valid after E0.
  - The ROM registers at E1.
  - The FIFO write happens at E2.
  - out_valid=1 after E2, i.e. the first coordinate appears 3 cycles after the start cycle.
- With out_ready held at 1, throughput is 1 coordinate/cycle. The last coordinate is presented NLEDS-1 cycles after the first. done pulses the cycle after the last handshake.
- Backpressure: the credit rule guarantees the FIFO never overflows. Issue stalls are at most 2 reads behind a full FIFO. Order is preserved and there are no duplicates.
- Simultaneous FIFO write and read: occupancy is unchanged. Read from empty or write to full is impossible by construction; assert it in simulation.
- rst mid-sweep: everything is cleared asynchronously. The next start begins from LED 0.
- A start on the same cycle as done is ignored, because the FSM is not yet in IDLE.

## Structure
- Shared package roseace_pkg:
  - ANGLE_W=9, LED_W=8, COORD_W=9, ROM_ADDR_W=15, ROM_DATA_W=20
  - ROM field positions
  - typedef enum quadrant_t {Q0,Q1,Q2,Q3}
  - typedef struct coord_t {x, y, led, last}
- Sub-module coord_fifo: 4-entry synchronous FIFO of coord_t with asynchronous rst, full/empty/occupancy. The top level holds the FSM, credit counter, tag pipeline and rotation.

## Test plan
- Reset: assert rst mid-stream → all outputs read 0 immediately; after release, a start at angle 0 restarts from LED 0, with rom_addr=0x0000.
- NLEDS=4, angle=0, out_ready=1, ROM model returning y=led+1, x=led → rom_addr 0x0000..0x0003; outputs (0,1),(1,2),(2,3),(3,4); out_last on the 4th; first out_valid 3 cycles after start; done one cycle after the last.
- angle=0x085 (q1, a=5), ROM x=10, y=20 → rom_addr 0x0500+led; outputs (−20, 10).
- q2 with x=255, y=0 → (−255, 0); q3 with x=3, y=7 → (7, −3).
- NLEDS=256, out_ready dropped for 10 cycles mid-sweep → at most 4 buffered plus 2 in flight; all 256 LEDs are delivered in order exactly once; rom_addr holds its value while stalled.
- start pulsed again during busy with a different angle → ignored; the sweep completes with the original angle and exactly one done pulse.

Source files
------------

// File: rtl/roseace_pkg.sv
// Shared types and constants for the rose-ace polar coordinate path.
// ROM field layout, quadrant encoding, coordinate bundle, rotation helper.
package roseace_pkg;

    localparam int ANGLE_W    = 9;
    localparam int LED_W      = 8;
    localparam int COORD_W    = 9;
    localparam int ROM_ADDR_W = 15;
    localparam int ROM_DATA_W = 20;

    localparam int ROM_X_LSB   = 0;
    localparam int ROM_Y_LSB   = 8;
    localparam int ROM_FIELD_W = 8;

    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic [LED_W-1:0]          led;
        logic                      last;
    } coord_t;

    // Quadrant-local (x, y) are magnitudes 0..255; rotation by q*90 deg
    // keeps the result within -255..255, so 9 signed bits always suffice.
    function automatic coord_t rotate(
        input quadrant_t              q,
        input logic [ROM_FIELD_W-1:0] xr,
        input logic [ROM_FIELD_W-1:0] yr,
        input logic [LED_W-1:0]       led,
        input logic                   last
    );
        coord_t                    c;
        logic signed [COORD_W-1:0] px;
        logic signed [COORD_W-1:0] py;
        px     = {1'b0, xr};
        py     = {1'b0, yr};
        c.led  = led;
        c.last = last;
        unique case (q)
            Q0: begin c.x = px;  c.y = py;  end
            Q1: begin c.x = -py; c.y = px;  end
            Q2: begin c.x = -px; c.y = -py; end
            Q3: begin c.x = py;  c.y = -px; end
            default: begin c.x = px; c.y = py; end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/coord_fifo.sv
// 4-entry synchronous FIFO of coord_t with asynchronous active-high reset.
// Ports: push/wdata in, pop/rdata out (head always visible), full, empty, occ.
module coord_fifo
    import roseace_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  coord_t     wdata,
    input  logic       pop,
    output coord_t     rdata,
    output logic       full,
    output logic       empty,
    output logic [2:0] occ
);

    coord_t     mem_q [FIFO_DEPTH];
    logic [1:0] wr_q;
    logic [1:0] rd_q;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    assign rdata = mem_q[rd_q];
    assign occ   = cnt_q;
    assign full  = (cnt_q == 3'(FIFO_DEPTH));
    assign empty = (cnt_q == 3'd0);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= wr_q + 2'd1;
            end
            if (pop) begin
                rd_q <= rd_q + 2'd1;
            end
            cnt_q <= cnt_d;
        end
    end

    // The upstream credit rule makes both of these unreachable.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (rst) !(push && full));
    a_no_underflow : assert property (
        @(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/polar_coord_fetch.sv
// Sweeps all LED indices per angular step through the precalc ROM, rotates
// into the right quadrant and streams signed centre-relative coordinates.
// Ports: start/angle in, rom_addr/rom_data ROM side, out_* valid/ready
// stream, busy during a sweep, done one-cycle pulse at sweep end.
module polar_coord_fetch
    import roseace_pkg::*;
#(
    parameter int NLEDS = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ANGLE_W-1:0]        angle,
    output logic [ROM_ADDR_W-1:0]     rom_addr,
    input  logic [ROM_DATA_W-1:0]     rom_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [COORD_W-1:0] out_x,
    output logic signed [COORD_W-1:0] out_y,
    output logic [LED_W-1:0]          out_led,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [LED_W-1:0] LAST_LED = LED_W'(NLEDS - 1);

    state_t               state_q, state_d;
    logic [ANGLE_W-1:0]   angle_q, angle_d;
    logic [LED_W-1:0]     led_q, led_d;
    logic [ROM_ADDR_W-1:0] addr_q;

    // Tag pipeline: stage 1 pairs with the address register,
    // stage 2 with the ROM output register.
    logic                 v1_q, v2_q;
    logic [LED_W-1:0]     led1_q, led2_q;
    quadrant_t            qd1_q, qd2_q;

    logic                 issue;
    logic [LED_W-1:0]     iss_led;
    logic [1:0]           inflight;
    logic [3:0]           used;
    logic                 credit_ok;

    logic                 push, pop;
    coord_t               wdata, rdata;
    logic                 full, empty;
    logic [2:0]           occ;
    logic                 unused_rom_hi;

    assign inflight  = 2'(v1_q) + 2'(v2_q);
    assign used      = 4'(occ) + 4'(inflight);
    assign credit_ok = (used < 4'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        angle_d = angle_q;
        led_d   = led_q;
        issue   = 1'b0;
        iss_led = led_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // The first read goes out on the start edge itself.
                    angle_d = angle;
                    issue   = 1'b1;
                    iss_led = '0;
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if (inflight == 2'd0 && occ == 3'd0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            led_d   = iss_led + LED_W'(1);
            state_d = (iss_led == LAST_LED) ? DRAIN : ISSUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            angle_q <= '0;
            led_q   <= '0;
            addr_q  <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            led1_q  <= '0;
            led2_q  <= '0;
            qd1_q   <= Q0;
            qd2_q   <= Q0;
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
            led_q   <= led_d;
            if (issue) begin
                addr_q <= {angle_d[6:0], iss_led};
                led1_q <= iss_led;
                qd1_q  <= quadrant_t'(angle_d[8:7]);
            end
            v1_q   <= issue;
            v2_q   <= v1_q;
            led2_q <= led1_q;
            qd2_q  <= qd1_q;
        end
    end

    assign push  = v2_q;
    assign wdata = rotate(qd2_q,
                          rom_data[ROM_X_LSB +: ROM_FIELD_W],
                          rom_data[ROM_Y_LSB +: ROM_FIELD_W],
                          led2_q,
                          led2_q == LAST_LED);
    assign unused_rom_hi = ^{rom_data[ROM_DATA_W-1:16], full};

    coord_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .occ   (occ)
    );

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign out_x     = rdata.x;
    assign out_y     = rdata.y;
    assign out_led   = rdata.led;
    assign out_last  = rdata.last;
    assign rom_addr  = addr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_polar_coord_fetch.sv
// Scoreboard bench: NLEDS=4 and NLEDS=256 instances sharing a ROM model.
// Expectations are queued at start and popped on each output handshake.
module tb_polar_coord_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic        sel;
    logic [8:0]  angle;
    int          rom_mode;

    logic [14:0] rom_addr_a, rom_addr_b;
    logic [19:0] rom_data_a, rom_data_b;
    logic        valid_a, valid_b;
    logic [8:0]  x_a, y_a, x_b, y_b;
    logic [7:0]  led_a, led_b;
    logic        last_a, last_b, busy_a, busy_b, done_a, done_b;

    logic        start_a, start_b;
    logic        mon_valid, mon_done;
    logic [26:0] mon_obs;
    logic [14:0] mon_addr;

    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;
    logic [26:0] exp_q[$];

    always #5 clk = ~clk;

    assign start_a   = start & ~sel;
    assign start_b   = start & sel;
    assign mon_valid = sel ? valid_b : valid_a;
    assign mon_done  = sel ? done_b : done_a;
    assign mon_addr  = sel ? rom_addr_b : rom_addr_a;
    assign mon_obs   = sel ? {x_b, y_b, led_b, last_b}
                           : {x_a, y_a, led_a, last_a};

    polar_coord_fetch #(.NLEDS(4)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .angle(angle),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .out_valid(valid_a), .out_ready(ready),
        .out_x(x_a), .out_y(y_a), .out_led(led_a), .out_last(last_a),
        .busy(busy_a), .done(done_a)
    );

    polar_coord_fetch #(.NLEDS(256)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .angle(angle),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .out_valid(valid_b), .out_ready(ready),
        .out_x(x_b), .out_y(y_b), .out_led(led_b), .out_last(last_b),
        .busy(busy_b), .done(done_b)
    );

    function automatic logic [19:0] rom_fn(input int mode, input logic [14:0] a);
        logic [7:0] x, y;
        case (mode)
            0: begin x = a[7:0]; y = a[7:0] + 8'd1; end
            1: begin x = 8'd10;  y = 8'd20; end
            2: begin x = 8'd255; y = 8'd0; end
            3: begin x = 8'd3;   y = 8'd7; end
            default: begin x = a[7:0]; y = ~a[7:0]; end
        endcase
        return {4'hA, y, x};
    endfunction

    always @(posedge clk) begin
        rom_data_a <= rom_fn(rom_mode, rom_addr_a);
        rom_data_b <= rom_fn(rom_mode, rom_addr_b);
    end

    function automatic logic [26:0] model(input logic [1:0] q,
                                          input logic [7:0] x,
                                          input logic [7:0] y,
                                          input logic [7:0] led,
                                          input logic       last);
        logic [8:0] px, py, ex, ey;
        px = {1'b0, x};
        py = {1'b0, y};
        case (q)
            2'd0: begin ex = px;      ey = py;      end
            2'd1: begin ex = 9'd0-py; ey = px;      end
            2'd2: begin ex = 9'd0-px; ey = 9'd0-py; end
            default: begin ex = py;   ey = 9'd0-px; end
        endcase
        return {ex, ey, led, last};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mon_valid && ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_out", 1, 0);
            end else begin
                chk("coord", mon_obs, exp_q.pop_front());
            end
            hs_cnt++;
        end
    end

    task automatic drive_start(input logic [8:0] ang, input int n);
        for (int i = 0; i < n; i++) begin
            logic [19:0] r;
            r = rom_fn(rom_mode, {ang[6:0], 8'(i)});
            exp_q.push_back(model(ang[8:7], r[7:0], r[15:8], 8'(i), i == n-1));
        end
        @(posedge clk);
        #1;
        angle = ang;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (mon_done) seen = 1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mon_valid) seen = 1;
        end
        if (!seen) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        int first, last_hs, done_at, dcnt;
        logic [14:0] a5;
        int outst;

        rst = 1'b1; start = 1'b0; ready = 1'b1; sel = 1'b0;
        angle = '0; rom_mode = 0;
        #12;
        chk("rst_a", {rom_addr_a, valid_a, x_a, y_a, led_a, last_a, busy_a, done_a}, 0);
        chk("rst_b", {rom_addr_b, valid_b, x_b, y_b, led_b, last_b, busy_b, done_b}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // NLEDS=4 basic sweep with latency / last / done timing
        first = 0; last_hs = 0; done_at = 0;
        drive_start(9'h000, 4);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c <= 4) chk("addr_seq", rom_addr_a, 15'(c-1));
            if (first == 0 && valid_a) first = c;
            if (valid_a && ready && last_a) last_hs = c;
            if (done_a) begin done_at = c; break; end
        end
        chk("first_lat", first, 3);
        chk("last_pos", last_hs, first + 3);
        chk("done_pos", done_at, last_hs + 1);

        // quadrant 1, a=5
        rom_mode = 1;
        drive_start(9'h085, 4);
        @(negedge clk);
        chk("addr_q1", rom_addr_a, 15'h0500);
        wait_valid();
        chk("q1_x", x_a, 9'h1EC);
        chk("q1_y", y_a, 9'd10);
        wait_done();

        // quadrant 2
        rom_mode = 2;
        drive_start(9'h100, 4);
        wait_valid();
        chk("q2_x", x_a, 9'h101);
        chk("q2_y", y_a, 9'd0);
        wait_done();

        // quadrant 3
        rom_mode = 3;
        drive_start(9'h180, 4);
        wait_valid();
        chk("q3_x", x_a, 9'd7);
        chk("q3_y", y_a, 9'h1FD);
        wait_done();

        // start while busy is ignored
        rom_mode = 0;
        drive_start(9'h000, 4);
        @(posedge clk);
        #1;
        angle = 9'h085;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_a) dcnt++;
        end
        chk("one_done", dcnt, 1);
        chk("q_empty_busy", exp_q.size(), 0);

        // start coincident with done is ignored
        drive_start(9'h000, 4);
        wait_done();
        start = 1'b1;
        angle = 9'h000;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_on_done", busy_a, 0);
        repeat (8) @(negedge clk);
        chk("q_empty_done", exp_q.size(), 0);

        // NLEDS=256 with a 10-cycle backpressure window
        sel = 1'b1;
        rom_mode = 4;
        hs_cnt = 0;
        a5 = '0;
        drive_start(9'h1C3, 256);
        repeat (40) @(negedge clk);
        ready = 1'b0;
        for (int s = 1; s <= 10; s++) begin
            @(negedge clk);
            if (s == 5) a5 = rom_addr_b;
        end
        chk("addr_hold", rom_addr_b, a5);
        outst = int'(rom_addr_b[7:0]) + 1 - hs_cnt;
        chk("outstanding_le6", outst <= 6, 1);
        ready = 1'b1;
        wait_done();
        chk("cnt256", hs_cnt, 256);
        chk("q_empty_256", exp_q.size(), 0);

        // reset mid-sweep, then restart from LED 0
        drive_start(9'h042, 256);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_b", {rom_addr_b, valid_b, x_b, y_b, led_b, last_b, busy_b, done_b}, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        hs_cnt = 0;
        drive_start(9'h000, 256);
        @(negedge clk);
        chk("restart_addr", mon_addr, 15'h0000);
        chk("restart_busy", busy_b, 1);
        wait_done();
        chk("cnt_restart", hs_cnt, 256);
        chk("q_empty_end", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
